// File: rtl/rtlola_pkg.sv
// Shared types for the RTLola monitor ingress path: the queued event record,
// the monitor's LLC pipeline length and the feeder FSM encoding.
package rtlola_pkg;

    typedef struct packed {
        logic        a;
        logic        new_a;
        logic        b;
        logic        new_b;
        logic [63:0] id;
        logic        new_id;
    } input_event_t;

    localparam int NUM_LLC_STAGES = 5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/monitor_input_feeder_sync_fifo.sv
// Single-clock FIFO with registered storage; the head entry is readable
// combinationally so the consumer can pop and use the data in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Requests against a full/empty FIFO are dropped here, so callers may
    // drive wr_en/rd_en without gating.
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/monitor_input_feeder.sv
// Ingress stage of the RTLola monitor: buffers producer events and presents
// each one for a single cycle aligned with the monitor's llc_stage 0.
module monitor_input_feeder
    import rtlola_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int NUM_STAGES = NUM_LLC_STAGES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ev_valid,
    output logic                      ev_ready,
    input  logic                      ev_a,
    input  logic                      ev_new_a,
    input  logic                      ev_b,
    input  logic                      ev_new_b,
    input  logic signed [63:0]        ev_id,
    input  logic                      ev_new_id,
    input  logic signed [63:0]        llc_stage,
    output logic                      input_a,
    output logic                      new_input_a,
    output logic                      input_b,
    output logic                      new_input_b,
    output logic signed [63:0]        input_id,
    output logic                      new_input_id,
    output logic                      en,
    output logic [$clog2(DEPTH):0]    fill,
    output logic [31:0]               dispatched,
    output logic                      state_dbg
);

    // Handshake: an event transfers on a rising edge where ev_valid && ev_ready;
    // ev_ready is !full only and never looks at a same-cycle pop.

    localparam logic signed [63:0] LAST_STAGE = 64'(NUM_STAGES - 1);

    input_event_t  push_ev;
    input_event_t  head_ev;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    feeder_state_t state;
    feeder_state_t state_next;

    assign push_ev = {ev_a, ev_new_a, ev_b, ev_new_b, ev_id, ev_new_id};
    assign ev_ready  = !fifo_full;
    assign en        = (state == S_RUN);
    assign state_dbg = state;

    sync_fifo #(
        .WIDTH ($bits(input_event_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ev_valid),
        .wr_data (push_ev),
        .rd_en   (pop),
        .rd_data (head_ev),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fill)
    );

    // The first dispatch leaves IDLE immediately because the monitor's stage
    // counter is parked at 0 while en is low; afterwards loading on the last
    // stage makes the event visible during stage 0.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if ((llc_stage == LAST_STAGE) && !fifo_empty) begin
                    pop = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !pop) begin
            input_a      <= 1'b0;
            new_input_a  <= 1'b0;
            input_b      <= 1'b0;
            new_input_b  <= 1'b0;
            input_id     <= '0;
            new_input_id <= 1'b0;
        end else begin
            input_a      <= head_ev.a;
            new_input_a  <= head_ev.new_a;
            input_b      <= head_ev.b;
            new_input_b  <= head_ev.new_b;
            input_id     <= head_ev.id;
            new_input_id <= head_ev.new_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dispatched <= '0;
        end else if (pop) begin
            dispatched <= dispatched + 32'd1;
        end
    end

endmodule
